crc_transmitter: RTL and testbench
==================================

Name: crc_transmitter

Overview:
- Upstream neighbour of the CRC receiver: encodes BW-bit data words into (BW+CRC_BW)-bit systematic CRC codewords, which cross the channel, pick up noise, and are decoded by the receiver.
- Computes the CRC bit-serially with an LFSR, MSB first, one bit per clock.
- Valid/ready handshake on both sides; one-word output hold register.

Parameters:
- BW, 4, data word width (>=1)
- CRC_BW, 3, CRC width (>=2)
- POLY, 3'b011, generator polynomial without its implicit x^CRC_BW term; default is G = x^3+x+1 (1011). Width is CRC_BW.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- in_data  in  BW  data word to encode
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  BW+CRC_BW  codeword = {data, crc}; data in the MSBs
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data

Behaviour:
- Reset (async, rstn=0): state=IDLE, data_reg=0, lfsr=0, cnt=0, out_valid=0, out_data=0. in_ready is combinational; it is 1 in IDLE, so it reads 1 during reset. A reset asserted mid-SHIFT or mid-HOLD drops the word in flight, with no partial output.
- CRC definition: crc = (data * x^CRC_BW) mod G over GF(2).
- Serial step per data bit b, MSB first: fb = b ^ lfsr[CRC_BW-1]; lfsr <= {lfsr[CRC_BW-2:0],1'b0} ^ (fb ? POLY : 0).
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch data_reg=in_data, lfsr=0, cnt=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle apply one step with b=data_reg[BW-1-cnt], then cnt++. When the step with cnt==BW-1 completes: out_data <= {data_reg, next lfsr}, out_valid <= 1, go to HOLD.
  - HOLD: out_valid=1; out_data stays stable until the output handshake. in_ready = out_ready (combinational).
    - out_ready=1 and in_valid=1: the output handshake and a new input accept happen on the same edge. Latch the new word, clear lfsr and cnt, go to SHIFT, and set out_valid <= 0.
    - out_ready=1 and in_valid=0: set out_valid <= 0, go to IDLE.
    - out_ready=0: hold all state and outputs.
- Latency: input accepted at edge k -> out_valid high after edge k+BW.
- Throughput: one word per BW+1 cycles with out_ready held at 1. No word is dropped or duplicated under any out_ready pattern.
- in_data is sampled only at the accepting edge; it may change freely at other times.

Optional Feature:
- Macro: CRC_ERR_INJECT_EN.
- When defined, two extra ports are added:
  - err_en  in  1  inject an error into the next codeword
  - err_pos  in  $clog2(BW+CRC_BW)  bit index to corrupt
- err_en and err_pos are sampled at the edge that accepts the input word. At the SHIFT->HOLD load, out_data bit err_pos is inverted.
- err_pos >= BW+CRC_BW means no flip.
- This produces noisy codewords for receiver testing.
- Without the macro: no extra ports, and out_data is always the clean codeword.

Decomposition:
- Package crc_pkg holds:
  - FSM state typedef (IDLE, SHIFT, HOLD)
  - default BW, CRC_BW, POLY constants
  - a function crc_ref(data) giving the combinational reference CRC, for benches and assertions
- One sub-module: crc_lfsr_serial (CRC_BW, POLY), with ports clk, rstn, clr, shift, bit_in, crc. The FSM and handshake logic stay in the top.

Test Plan:
- Reset then single word: in_data=4'b1101, out_ready=1 -> out_data=7'h69 (crc 001); out_valid rises 4 cycles after accept and lasts 1 cycle.
- Known vectors: in_data=4'h0 -> 7'h00; in_data=4'h8 -> 7'h45 (crc 101). Sweep all 16 inputs and compare against crc_ref.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_data and out_valid stay stable and in_ready=0. Then set out_ready=1 with in_valid=1 on the same cycle -> the next word is accepted on that same edge.
- Streaming: in_valid=1 and out_ready=1 continuously for 100 words -> one codeword every 5 cycles, in order, all matching crc_ref.
- Mid-operation reset: pull rstn low during SHIFT -> out_valid=0 immediately and no codeword is emitted. After release, in_ready=1 and the next word encodes correctly.
- With CRC_ERR_INJECT_EN: in_data=4'b1101, err_en=1, err_pos=0 -> out_data=7'h68. With err_pos=6 -> 7'h29. Fed into the receiver, the corrected data 4'b1101 is recovered.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC transmitter.
// Holds the FSM states, default geometry and a reference CRC function.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam int          BW_D     = 4;
  localparam int          CRC_BW_D = 3;
  localparam logic [2:0]  POLY_D   = 3'b011;

  // Whole-word CRC for the default geometry: (data * x^CRC_BW) mod G.
  function automatic logic [CRC_BW_D-1:0] crc_ref(
    input logic [BW_D-1:0] data
  );
    logic [CRC_BW_D-1:0] r;
    logic                fb;
    r = '0;
    for (int i = BW_D - 1; i >= 0; i--) begin
      fb = data[i] ^ r[CRC_BW_D-1];
      r  = {r[CRC_BW_D-2:0], 1'b0} ^ (fb ? POLY_D : '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Bit-serial CRC register, MSB-first data, one bit per shift.
// clr wins over shift; crc is the current register contents.
module crc_lfsr_serial #(
  parameter int                CRC_BW = 3,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(3'b011)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  output logic [CRC_BW-1:0] crc
);

  logic              w_fb;
  logic [CRC_BW-1:0] w_nxt;

  assign w_fb  = bit_in ^ crc[CRC_BW-1];
  assign w_nxt = {crc[CRC_BW-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  // Clear at word start, otherwise fold in one data bit per shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (shift) begin
      crc <= w_nxt;
    end
  end

endmodule

// File: rtl/crc_transmitter.sv
// Systematic CRC encoder: {data, crc} codewords over valid/ready.
// Optional CRC_ERR_INJECT_EN adds err_en/err_pos to flip one bit.
module crc_transmitter
  import crc_pkg::*;
#(
  parameter int                BW     = BW_D,
  parameter int                CRC_BW = CRC_BW_D,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(POLY_D)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BW+CRC_BW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CRC_ERR_INJECT_EN
  ,
  input  logic                 err_en,
  input  logic [$clog2(BW+CRC_BW)-1:0] err_pos
`endif
);

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam int OW = BW + CRC_BW;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_data;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_idx;
  logic              w_bit;
  logic              w_last;
  logic              w_accept;
  logic              w_shift;
  logic              w_load;
  logic              w_fb;
  logic [CRC_BW-1:0] w_crc;
  logic [CRC_BW-1:0] w_crc_nxt;
  logic [OW-1:0]     w_flip;
  logic [OW-1:0]     r_out_data;
  logic              r_out_valid;

  assign w_idx    = CW'(BW - 1) - r_cnt;
  assign w_bit    = r_data[w_idx];
  assign w_last   = (r_cnt == CW'(BW - 1));
  assign w_accept = in_valid & in_ready;

  // The codeword is loaded on the edge of the final shift, so the
  // post-shift CRC value is formed here alongside the register.
  assign w_fb      = w_bit ^ w_crc[CRC_BW-1];
  assign w_crc_nxt = {w_crc[CRC_BW-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  crc_lfsr_serial #(
    .CRC_BW (CRC_BW),
    .POLY   (POLY)
  ) u_lfsr (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (w_accept),
    .shift  (w_shift),
    .bit_in (w_bit),
    .crc    (w_crc)
  );

`ifdef CRC_ERR_INJECT_EN
  logic                     r_err_en;
  logic [$clog2(OW)-1:0]    r_err_pos;

  // Error request travels with the word accepted on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_en  <= 1'b0;
      r_err_pos <= '0;
    end else if (w_accept) begin
      r_err_en  <= err_en;
      r_err_pos <= err_pos;
    end
  end

  // Out-of-range positions leave the codeword clean.
  always_comb begin
    w_flip = '0;
    if (r_err_en && (int'(r_err_pos) < OW)) begin
      w_flip[r_err_pos] = 1'b1;
    end
  end
`else
  assign w_flip = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake/strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_state_nxt = in_valid ? SHIFT : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word latch, bit counter and output hold register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data      <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_out_data  <= {r_data, w_crc_nxt} ^ w_flip;
        r_out_valid <= 1'b1;
      end else if (r_state == HOLD && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_crc_transmitter.sv
// Scoreboard bench for crc_transmitter (default 4-bit data, 3-bit CRC).
// Expected codewords come from GF(2) long division in the bench.
module tb_crc_transmitter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef CRC_ERR_INJECT_EN
  logic       err_en = 1'b0;
  logic [2:0] err_pos = '0;
`endif

  crc_transmitter dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CRC_ERR_INJECT_EN
    ,
    .err_en    (err_en),
    .err_pos   (err_pos)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cw;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stream_chk = 0;
  int   last_rise = 0;
  logic prev_ov = 1'b0;
  int   accepts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Remainder of d * x^3 divided by x^3+x+1 (binary 1011).
  function automatic logic [6:0] model(logic [3:0] d);
    int rem;
    rem = int'(d) << 3;
    for (int i = 6; i >= 3; i--) begin
      if (rem[i]) rem = rem ^ (11 << (i - 3));
    end
    return {d, rem[2:0]};
  endfunction

  // Drive one cycle; record the expected word if it is accepted.
  task automatic step(bit iv, logic [3:0] d, bit orr, logic [6:0] e);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    #1;
    if (rstn && in_valid && in_ready) begin
      q.push_back('{cw: e, acc: cyc + 1});
      accepts++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      step(0, 4'($urandom), 1, '0);
      n++;
    end
    step(0, 4'($urandom), 1, '0);
    chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor: latency, spacing and codeword checks on each handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rstn) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() > 0) chk("latency", cyc, q[0].acc + 4);
        if (stream_chk && last_rise != 0) chk("spacing", cyc - last_rise, 5);
        last_rise = cyc;
      end
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {25'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("codeword", out_data, e.cw);
        end
      end
    end
  end

  initial begin
    logic [3:0] d;
    int n;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    step(1, 4'hD, 1, 7'h69);
    drain();
    chk("valid_one_cycle", out_valid, 0);

    step(1, 4'h0, 1, 7'h00);
    drain();
    step(1, 4'h8, 1, 7'h45);
    drain();

    for (int i = 0; i < 16; i++) begin
      step(1, 4'(i), 1, model(4'(i)));
      drain();
    end

    d = 4'($urandom);
    step(1, d, 0, model(d));
    n = 0;
    while (!out_valid && n < 10) begin
      step(0, '0, 0, '0);
      n++;
    end
    chk("bp_reach_hold", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 4'($urandom), 0, 7'h7F);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, model(d));
      chk("bp_in_ready", in_ready, 0);
    end
    d = 4'($urandom);
    step(1, d, 1, model(d));
    chk("bp_same_edge_accept", in_ready, 1);
    drain();

    stream_chk = 1;
    last_rise  = 0;
    accepts    = 0;
    n = 0;
    while (accepts < 100 && n < 700) begin
      d = 4'($urandom);
      step(1, d, 1, model(d));
      n++;
    end
    chk("stream_count", accepts, 100);
    drain();
    stream_chk = 0;

    for (int i = 0; i < 400; i++) begin
      d = 4'($urandom);
      step(1'($urandom_range(0, 1)), d,
           ($urandom_range(0, 3) != 0), model(d));
    end
    drain();

    for (int k = 0; k < 2; k++) begin
      d = 4'($urandom);
      step(1, d, 0, model(d));
      repeat (k == 0 ? 2 : 6) step(0, '0, 0, '0);
      @(negedge clk);
      rstn = 1'b0;
      q.delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      repeat (8) step(0, '0, 1, '0);
      d = 4'($urandom);
      step(1, d, 1, model(d));
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
